// File: rtl/esp8266_pkg.sv
// rtl/esp8266_pkg.sv - shared TX state encoding and UART frame constants
package esp8266_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    function automatic int bit_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/esp8266_byte_fifo.sv
// rtl/esp8266_byte_fifo.sv - single-clock byte FIFO with occupancy count
// Full/empty come from the registered count, so a new byte is only readable the cycle after its write.
module esp8266_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/esp8266_uart_tx.sv
// rtl/esp8266_uart_tx.sv - buffered 8N1 UART transmitter fed by an asynchronous byte strobe
module esp8266_uart_tx
    import esp8266_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_NUL   = 1
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    input  logic                           Sig,
    input  logic [7:0]                     Data_send,
    output logic                           Tx,
    output logic                           Busy,
    output logic [$clog2(FIFO_DEPTH):0]    Fifo_count,
    output logic                           Overflow
);

    localparam int DIV = bit_period(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic sync1;
    logic sync2;
    logic sync3;
    logic sync_seen;
    logic armed;
    logic wr_req;
    logic push;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       pop;

    tx_state_t            state;
    logic [CW-1:0]        baud_cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [7:0]           shreg;
    logic                 tx_q;

    // armed only after a genuine low sample of Sig, so a strobe already high at reset release is ignored
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            sync_seen <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync1     <= Sig;
            sync2     <= sync1;
            sync3     <= sync2;
            sync_seen <= 1'b1;
            if (sync_seen && !sync1) begin
                armed <= 1'b1;
            end
        end
    end

    assign wr_req = sync2 && !sync3 && armed;
    assign push   = wr_req && !((DROP_NUL != 0) && (Data_send == 8'h00));
    assign pop    = (state == ST_IDLE) && !fifo_empty;

    esp8266_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .wr_en   (push),
        .wr_data (Data_send),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .count   (Fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Overflow <= 1'b0;
        end else if (push && fifo_full) begin
            Overflow <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q     <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!fifo_empty) begin
                        shreg <= fifo_data;
                        tx_q  <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        tx_q     <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            tx_q    <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_q    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_IDX_W'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign Tx   = tx_q;
    assign Busy = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_esp8266_uart_tx.sv
// tb/tb_esp8266_uart_tx.sv - self-checking bench for esp8266_uart_tx
module tb_esp8266_uart_tx;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       sig = 1'b0;
    logic       sig0 = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] data0 = 8'h00;
    logic       tx, busy, ovf, tx0, busy0, ovf0;
    logic [2:0] cnt, cnt0;

    int total = 0;
    int bad = 0;

    logic [7:0] rx_q[$];
    int         p_time[$];
    logic [7:0] p_data[$];
    logic       s_tx   [0:2047];
    logic       s_busy [0:2047];
    logic       s_ovf  [0:2047];
    logic [2:0] s_cnt  [0:2047];

    typedef struct {
        logic [7:0] d;
        bit         sel;
        bit         sent;
    } vec_t;
    vec_t vecs[6];

    always #5 Clk = ~Clk;

    esp8266_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4), .DROP_NUL(1)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Sig(sig), .Data_send(data),
        .Tx(tx), .Busy(busy), .Fifo_count(cnt), .Overflow(ovf)
    );

    esp8266_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4), .DROP_NUL(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Sig(sig0), .Data_send(data0),
        .Tx(tx0), .Busy(busy0), .Fifo_count(cnt0), .Overflow(ovf0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Frames are back-to-back from the first pop: start at 4, each 10 bits of 10 cycles plus 1 idle cycle.
    function automatic logic exp_tx_at(input int k, input logic [7:0] fr[$]);
        logic [9:0] f;
        int st;
        for (int j = 0; j < fr.size(); j++) begin
            st = 4 + 101 * j;
            if (k >= st && k < st + 100) begin
                f = {1'b1, fr[j], 1'b0};
                return f[(k - st) / 10];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy_at(input int k, input int n);
        return (n > 0) && (k >= 3) && (k < 101 * n + 3);
    endfunction

    task automatic run_sched(input bit sel, input int len);
        bit         act;
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            @(posedge Clk);
            #1;
            act = 1'b0;
            d   = 8'h00;
            for (int j = 0; j < p_time.size(); j++) begin
                if (k >= p_time[j] && k < p_time[j] + 6) begin
                    act = 1'b1;
                    d   = p_data[j];
                end
            end
            if (sel) begin
                sig0 = act;
                if (act) data0 = d;
            end else begin
                sig = act;
                if (act) data = d;
            end
            @(negedge Clk);
            s_tx[k]   = sel ? tx0 : tx;
            s_busy[k] = sel ? busy0 : busy;
            s_ovf[k]  = sel ? ovf0 : ovf;
            s_cnt[k]  = sel ? cnt0 : cnt;
        end
        sig  = 1'b0;
        sig0 = 1'b0;
    endtask

    task automatic check_frames(input string name, input int len, input logic [7:0] fr[$]);
        int   mk, bk;
        logic ma, me, ba, be;
        mk = len - 1; ma = s_tx[mk];   me = exp_tx_at(mk, fr);
        bk = len - 1; ba = s_busy[bk]; be = exp_busy_at(bk, fr.size());
        for (int k = 0; k < len; k++) begin
            if (s_tx[k] !== exp_tx_at(k, fr)) begin
                mk = k; ma = s_tx[k]; me = exp_tx_at(k, fr);
                break;
            end
        end
        for (int k = 0; k < len; k++) begin
            if (s_busy[k] !== exp_busy_at(k, fr.size())) begin
                bk = k; ba = s_busy[k]; be = exp_busy_at(k, fr.size());
                break;
            end
        end
        chk($sformatf("%s_tx@%0d", name, mk), ma, me);
        chk($sformatf("%s_busy@%0d", name, bk), ba, be);
    endtask

    task automatic check_rx(input string name, input logic [7:0] fr[$]);
        chk($sformatf("%s_rxlen", name), rx_q.size(), fr.size());
        for (int i = 0; i < fr.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_rx%0d", name, i), rx_q[i], fr[i]);
        end
    endtask

    // Passive UART receiver sampling mid-bit on the first DUT's line.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge Clk);
            if (Rst_n === 1'b1 && tx === 1'b0) begin
                repeat (4) @(negedge Clk);
                chk("mon_start", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge Clk);
                    b[i] = tx;
                end
                repeat (10) @(negedge Clk);
                chk("mon_stop", tx, 1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : main
        logic [7:0] fq[$];
        int         t, n, len, lows, maxc;
        logic [7:0] d;

        vecs[0] = '{8'h41, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'hA5, 1'b1, 1'b1};

        repeat (3) @(negedge Clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tx0", tx0, 1);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (5) @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            p_time = {};  p_data = {};
            p_time.push_back(0);
            p_data.push_back(vecs[i].d);
            rx_q.delete();
            run_sched(vecs[i].sel, 115);
            fq = {};
            if (vecs[i].sent) fq.push_back(vecs[i].d);
            check_frames($sformatf("vec%0d", i), 115, fq);
            chk($sformatf("vec%0d_cnt3", i), s_cnt[3], vecs[i].sent ? 1 : 0);
            chk($sformatf("vec%0d_cnt4", i), s_cnt[4], 0);
            if (!vecs[i].sel) check_rx($sformatf("vec%0d", i), fq);
        end

        // six strobes while the line is busy: the last one finds the FIFO full
        p_time = {};  p_data = {};  fq = {};
        for (int i = 0; i < 6; i++) begin
            p_time.push_back(20 * i);
            p_data.push_back(8'h31 + 8'(i));
            if (i < 5) fq.push_back(8'h31 + 8'(i));
        end
        rx_q.delete();
        run_sched(0, 540);
        chk("burst_cnt99", s_cnt[99], 4);
        chk("burst_ovf102", s_ovf[102], 0);
        chk("burst_ovf103", s_ovf[103], 1);
        chk("burst_cnt105", s_cnt[105], 3);
        check_frames("burst", 540, fq);
        check_rx("burst", fq);

        // writes coinciding with pops at count 2, ten bytes through the depth-4 FIFO
        p_time = {};  p_data = {};  fq = {};
        for (int i = 0; i < 10; i++) begin
            p_time.push_back(i < 3 ? 20 * i : 102 + 101 * (i - 3));
            p_data.push_back(8'hA0 + 8'(i));
            fq.push_back(8'hA0 + 8'(i));
        end
        rx_q.delete();
        run_sched(0, 1030);
        for (int m = 0; m < 7; m++) begin
            chk($sformatf("wrap_cnt_pre%0d", m), s_cnt[104 + 101 * m], 2);
            chk($sformatf("wrap_cnt_post%0d", m), s_cnt[105 + 101 * m], 2);
        end
        check_frames("wrap", 1030, fq);
        check_rx("wrap", fq);

        // reset in the middle of data bit 3
        p_time = {0, 20};  p_data = {8'h55, 8'h12};
        run_sched(0, 48);
        chk("midrst_pre_tx", s_tx[47], 0);
        chk("midrst_pre_cnt", s_cnt[47], 1);
        @(posedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_cnt", cnt, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        p_time = {};  p_data = {};  fq = {};
        run_sched(0, 250);
        check_frames("postrst", 250, fq);
        rx_q.delete();

        // strobe held high across reset release
        @(posedge Clk);
        #1 Rst_n = 1'b0;
        sig  = 1'b1;
        data = 8'h0D;
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        lows = 0;
        maxc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (tx !== 1'b1) lows++;
            if (int'(cnt) > maxc) maxc = int'(cnt);
        end
        chk("heldsig_txlow", lows, 0);
        chk("heldsig_cnt", maxc, 0);
        @(posedge Clk);
        #1 sig = 1'b0;
        repeat (10) @(negedge Clk);
        rx_q.delete();
        p_time = {0};  p_data = {8'h0D};  fq = {8'h0D};
        run_sched(0, 115);
        check_frames("heldsig", 115, fq);
        check_rx("heldsig", fq);
        chk("heldsig_ovf", ovf, 0);

        // random bursts sized so the FIFO never overflows
        for (int b = 0; b < 6; b++) begin
            p_time = {};  p_data = {};  fq = {};
            t = 0;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                p_time.push_back(t);
                p_data.push_back(d);
                if (d != 8'h00) fq.push_back(d);
                t += $urandom_range(15, 30);
            end
            len = t + 5 * 101 + 30;
            rx_q.delete();
            run_sched(0, len);
            check_rx($sformatf("rnd%0d", b), fq);
            chk($sformatf("rnd%0d_busy", b), s_busy[len - 1], 0);
            chk($sformatf("rnd%0d_cnt", b), s_cnt[len - 1], 0);
            chk($sformatf("rnd%0d_ovf", b), s_ovf[len - 1], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
